// File: rtl/store_write_buffer_pkg.sv
// Shared size encodings and lane helpers for the store write buffer.
// Helpers work on a 64-bit lane; narrower datapaths take the low bits.
package store_write_buffer_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // Byte strobes for a store of the given size at lane offset off.
    function automatic logic [7:0] size_to_strb(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            SIZE_B:  base = 8'h01;
            SIZE_H:  base = 8'h03;
            SIZE_W:  base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Right-aligned store data replicated across every lane position.
    function automatic logic [63:0] replicate(input logic [63:0] data, input logic [1:0] size);
        logic [63:0] rep;
        case (size)
            SIZE_B:  rep = {8{data[7:0]}};
            SIZE_H:  rep = {4{data[15:0]}};
            SIZE_W:  rep = {2{data[31:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    // Natural alignment check; dword only exists on a 64-bit datapath.
    function automatic logic is_legal(input logic [1:0] size, input logic [2:0] off,
                                      input logic dword_ok);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = (off[0] == 1'b0);
            SIZE_W:  ok = (off[1:0] == 2'b00);
            default: ok = dword_ok && (off == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_write_buffer_sync_fifo.sv
// In-order FIFO with per-entry valid bits and a tap on the top TAP_W bits of each entry.
module store_write_buffer_sync_fifo #(
    parameter int unsigned WIDTH = 72,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAP_W = 32
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              push,
    input  logic                              pop,
    input  logic [WIDTH-1:0]                  wdata,
    output logic [WIDTH-1:0]                  rdata,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(DEPTH):0]            count,
    output logic [DEPTH-1:0]                  entry_valid,
    output logic [DEPTH-1:0][TAP_W-1:0]       entry_tap
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [DEPTH-1:0] valid;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            valid  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                valid[rd_ptr] <= 1'b0;
            end
            if (do_push) begin
                wr_ptr        <= wr_ptr + PTR_W'(1);
                valid[wr_ptr] <= 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata       = mem[rd_ptr];
    assign count       = cnt;
    assign entry_valid = valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_tap
        assign entry_tap[i] = mem[i][WIDTH-1 -: TAP_W];
    end

endmodule

// File: rtl/store_write_buffer.sv
// EX-stage store formatting (strobes, lane replication, alignment check) feeding an
// in-order write buffer that drains to data memory and flags load/store word hazards.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_size,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_data,
    output logic                      err_ades,
    output logic [ADDR_W-1:0]         err_badvaddr,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W/8-1:0]       mem_strb,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [ADDR_W-1:0]         ld_addr,
    output logic                      ld_hit,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned ENT_W  = ADDR_W + STRB_W + DATA_W;

    logic [2:0]                   off;
    logic                         legal;
    logic                         accept;
    logic                         push;
    logic                         pop;
    logic                         full;
    logic [ADDR_W-1:0]            ent_addr;
    logic [STRB_W-1:0]            ent_strb;
    logic [DATA_W-1:0]            ent_data;
    logic [ENT_W-1:0]             head;
    logic [ADDR_W-1:0]            ld_word;
    logic [DEPTH-1:0]             entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_tap;

    assign off      = 3'(req_addr[OFF_W-1:0]);
    assign legal    = is_legal(req_size, off, DATA_W == 64);
    assign req_ready = !full;
    assign accept   = req_valid && req_ready;
    assign push     = accept && legal;
    assign pop      = mem_valid && mem_ready;

    assign ent_addr = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign ent_strb = STRB_W'(size_to_strb(req_size, off));
    assign ent_data = DATA_W'(replicate(64'(req_data), req_size));

    store_write_buffer_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH),
        .TAP_W (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push        (push),
        .pop         (pop),
        .wdata       ({ent_addr, ent_strb, ent_data}),
        .rdata       (head),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_tap   (entry_tap)
    );

    assign mem_valid = !empty;
    assign {mem_addr, mem_strb, mem_wdata} = head;

    // Rejected stores still complete their handshake; report them one cycle later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_ades     <= 1'b0;
            err_badvaddr <= '0;
        end else begin
            err_ades <= accept && !legal;
            if (accept && !legal) begin
                err_badvaddr <= req_addr;
            end
        end
    end

    // Conservative hazard: any pending store to the same aligned word, strobes ignored.
    assign ld_word = {ld_addr[ADDR_W-1:OFF_W], OFF_W'(0)};

    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_tap[i] == ld_word)) begin
                ld_hit = 1'b1;
            end
        end
    end

endmodule
